// File: rtl/id_exe_hazard_pipe.sv
// rtl/id_exe_hazard_pipe.sv - ID->EXE pipeline register with counted load-use interlock, flush and back-pressure
module id_exe_hazard_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CMD_W      = 4,
    parameter int LOAD_STALL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_uses_src2,
    input  logic [DATA_W-1:0]     id_val1,
    input  logic [DATA_W-1:0]     id_val2,
    input  logic [DATA_W-1:0]     id_reg2,
    input  logic [CMD_W-1:0]      id_exe_cmd,
    input  logic                  id_mem_r_en,
    input  logic                  id_mem_w_en,
    input  logic                  id_wb_en,
    input  logic                  id_br_taken,
    input  logic                  exe_ready,
    input  logic                  flush,
    output logic                  exe_valid,
    output logic [REG_ADDR_W-1:0] exe_dest,
    output logic [REG_ADDR_W-1:0] exe_src1,
    output logic [REG_ADDR_W-1:0] exe_src2,
    output logic [DATA_W-1:0]     exe_val1,
    output logic [DATA_W-1:0]     exe_val2,
    output logic [DATA_W-1:0]     exe_reg2,
    output logic [CMD_W-1:0]      exe_cmd,
    output logic                  exe_mem_r_en,
    output logic                  exe_mem_w_en,
    output logic                  exe_wb_en,
    output logic                  exe_br_taken,
    output logic [15:0]           bubble_cnt
);

    typedef enum logic {S_RUN, S_STALL} state_t;

    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 1);

    state_t                r_state;
    logic [1:0]            r_cnt;
    logic [15:0]           r_bubble_cnt;
    logic                  r_exe_valid;
    logic [REG_ADDR_W-1:0] r_exe_dest;
    logic [REG_ADDR_W-1:0] r_exe_src1;
    logic [REG_ADDR_W-1:0] r_exe_src2;
    logic [DATA_W-1:0]     r_exe_val1;
    logic [DATA_W-1:0]     r_exe_val2;
    logic [DATA_W-1:0]     r_exe_reg2;
    logic [CMD_W-1:0]      r_exe_cmd;
    logic                  r_exe_mem_r_en;
    logic                  r_exe_mem_w_en;
    logic                  r_exe_wb_en;
    logic                  r_exe_br_taken;

    logic w_hazard;
    logic w_load_id;
    logic w_count_bubble;
    logic w_load_bubble;

    // Only a pending load that writes a non-zero register can stall the consumer in ID.
    assign w_hazard = (r_state == S_RUN) & r_exe_valid & r_exe_mem_r_en & r_exe_wb_en
                    & (r_exe_dest != '0) & id_valid
                    & ((id_src1 == r_exe_dest) | (id_uses_src2 & (id_src2 == r_exe_dest)));

    assign w_load_id      = ~flush & exe_ready & (r_state == S_RUN) & ~w_hazard;
    assign w_count_bubble = ~flush & exe_ready & ((r_state == S_STALL) | w_hazard);
    assign w_load_bubble  = flush | w_count_bubble;
    assign id_ready       = rst & w_load_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_RUN;
            r_cnt          <= '0;
            r_bubble_cnt   <= '0;
            r_exe_valid    <= 1'b0;
            r_exe_dest     <= '0;
            r_exe_src1     <= '0;
            r_exe_src2     <= '0;
            r_exe_val1     <= '0;
            r_exe_val2     <= '0;
            r_exe_reg2     <= '0;
            r_exe_cmd      <= '0;
            r_exe_mem_r_en <= 1'b0;
            r_exe_mem_w_en <= 1'b0;
            r_exe_wb_en    <= 1'b0;
            r_exe_br_taken <= 1'b0;
        end else begin
            if (w_load_bubble) begin
                r_exe_valid    <= 1'b0;
                r_exe_dest     <= '0;
                r_exe_src1     <= '0;
                r_exe_src2     <= '0;
                r_exe_val1     <= '0;
                r_exe_val2     <= '0;
                r_exe_reg2     <= '0;
                r_exe_cmd      <= '0;
                r_exe_mem_r_en <= 1'b0;
                r_exe_mem_w_en <= 1'b0;
                r_exe_wb_en    <= 1'b0;
                r_exe_br_taken <= 1'b0;
            end else if (w_load_id) begin
                r_exe_valid    <= id_valid;
                r_exe_dest     <= id_dest;
                r_exe_src1     <= id_src1;
                r_exe_src2     <= id_src2;
                r_exe_val1     <= id_val1;
                r_exe_val2     <= id_val2;
                r_exe_reg2     <= id_reg2;
                r_exe_cmd      <= id_exe_cmd;
                r_exe_mem_r_en <= id_mem_r_en;
                r_exe_mem_w_en <= id_mem_w_en;
                r_exe_wb_en    <= id_wb_en;
                r_exe_br_taken <= id_br_taken;
            end

            if (w_count_bubble && r_bubble_cnt != 16'hFFFF)
                r_bubble_cnt <= r_bubble_cnt + 16'd1;

            // Flush wins over any hazard or stall in progress.
            if (flush) begin
                r_state <= S_RUN;
                r_cnt   <= '0;
            end else if (exe_ready) begin
                case (r_state)
                    S_RUN: begin
                        if (w_hazard) begin
                            r_cnt   <= STALL_INIT;
                            r_state <= (LOAD_STALL > 1) ? S_STALL : S_RUN;
                        end
                    end
                    S_STALL: begin
                        r_cnt <= r_cnt - 2'd1;
                        if (r_cnt == 2'd1)
                            r_state <= S_RUN;
                    end
                    default: r_state <= S_RUN;
                endcase
            end
        end
    end

    assign exe_valid    = r_exe_valid;
    assign exe_dest     = r_exe_dest;
    assign exe_src1     = r_exe_src1;
    assign exe_src2     = r_exe_src2;
    assign exe_val1     = r_exe_val1;
    assign exe_val2     = r_exe_val2;
    assign exe_reg2     = r_exe_reg2;
    assign exe_cmd      = r_exe_cmd;
    assign exe_mem_r_en = r_exe_mem_r_en;
    assign exe_mem_w_en = r_exe_mem_w_en;
    assign exe_wb_en    = r_exe_wb_en;
    assign exe_br_taken = r_exe_br_taken;
    assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_exe_hazard_pipe.sv
// tb/tb_id_exe_hazard_pipe.sv - directed bench for id_exe_hazard_pipe with LOAD_STALL of 1 and 3
module tb_id_exe_hazard_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_src2;
    logic [4:0]  id_dest, id_src1, id_src2;
    logic [31:0] id_val1, id_val2, id_reg2;
    logic [3:0]  id_exe_cmd;
    logic        id_mem_r_en, id_mem_w_en, id_wb_en, id_br_taken;
    logic        exe_ready, flush;

    logic        a_id_ready, a_valid, a_mr, a_mw, a_wb, a_br;
    logic [4:0]  a_dest, a_src1, a_src2;
    logic [31:0] a_val1, a_val2, a_reg2;
    logic [3:0]  a_cmd;
    logic [15:0] a_bcnt;

    logic        b_id_ready, b_valid, b_mr, b_mw, b_wb, b_br;
    logic [4:0]  b_dest, b_src1, b_src2;
    logic [31:0] b_val1, b_val2, b_reg2;
    logic [3:0]  b_cmd;
    logic [15:0] b_bcnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_exe_hazard_pipe #(.LOAD_STALL(1)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(a_id_ready),
        .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
        .id_val1(id_val1), .id_val2(id_val2), .id_reg2(id_reg2), .id_exe_cmd(id_exe_cmd),
        .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_wb_en(id_wb_en),
        .id_br_taken(id_br_taken), .exe_ready(exe_ready), .flush(flush),
        .exe_valid(a_valid), .exe_dest(a_dest), .exe_src1(a_src1), .exe_src2(a_src2),
        .exe_val1(a_val1), .exe_val2(a_val2), .exe_reg2(a_reg2), .exe_cmd(a_cmd),
        .exe_mem_r_en(a_mr), .exe_mem_w_en(a_mw), .exe_wb_en(a_wb), .exe_br_taken(a_br),
        .bubble_cnt(a_bcnt)
    );

    id_exe_hazard_pipe #(.LOAD_STALL(3)) u3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(b_id_ready),
        .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
        .id_val1(id_val1), .id_val2(id_val2), .id_reg2(id_reg2), .id_exe_cmd(id_exe_cmd),
        .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_wb_en(id_wb_en),
        .id_br_taken(id_br_taken), .exe_ready(exe_ready), .flush(flush),
        .exe_valid(b_valid), .exe_dest(b_dest), .exe_src1(b_src1), .exe_src2(b_src2),
        .exe_val1(b_val1), .exe_val2(b_val2), .exe_reg2(b_reg2), .exe_cmd(b_cmd),
        .exe_mem_r_en(b_mr), .exe_mem_w_en(b_mw), .exe_wb_en(b_wb), .exe_br_taken(b_br),
        .bubble_cnt(b_bcnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] d, input logic [4:0] s1,
                             input logic [4:0] s2, input logic u2, input logic [31:0] v1,
                             input logic [3:0] cmd, input logic mr, input logic wb);
        id_valid = v; id_dest = d; id_src1 = s1; id_src2 = s2; id_uses_src2 = u2;
        id_val1 = v1; id_val2 = 32'h0; id_reg2 = 32'h0; id_exe_cmd = cmd;
        id_mem_r_en = mr; id_mem_w_en = 1'b0; id_wb_en = wb; id_br_taken = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0; exe_ready = 1'b1;
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
    endtask

    // Put a load writing r5 into EXE of both instances.
    task automatic load_r5();
        set_instr(1'b1, 5'd5, 5'd1, 5'd2, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_instr(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), $urandom,
                      4'($urandom), 1'($urandom), 1'($urandom));
            id_br_taken = 1'($urandom); exe_ready = 1'($urandom); flush = 1'($urandom);
            tick();
        end
        n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0h want 0", a_valid); end
        n_cmp++; if ({a_dest, a_val1, a_cmd, a_mr, a_wb, a_br} !== '0) begin n_bad++; $display("FAIL rst_fields got %0h want 0", {a_dest, a_val1, a_cmd, a_mr, a_wb, a_br}); end
        n_cmp++; if (a_id_ready !== 1'b0 || b_id_ready !== 1'b0) begin n_bad++; $display("FAIL rst_id_ready got %0h%0h want 00", a_id_ready, b_id_ready); end
        n_cmp++; if (a_bcnt !== 16'h0 || b_bcnt !== 16'h0) begin n_bad++; $display("FAIL rst_bcnt got %0h/%0h want 0", a_bcnt, b_bcnt); end
        flush = 1'b0; exe_ready = 1'b1;
        rst = 1'b1;
        #1;
        n_cmp++; if (a_id_ready !== 1'b1 || b_id_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got %0h%0h want 11", a_id_ready, b_id_ready); end
    endtask

    task automatic test_plain_advance();
        do_reset();
        set_instr(1'b1, 5'd3, 5'd1, 5'd2, 1'b0, 32'h11, 4'h2, 1'b0, 1'b1);
        tick();
        n_cmp++; if (a_valid !== 1'b1 || a_dest !== 5'd3) begin n_bad++; $display("FAIL adv_valid_dest got %0h/%0d want 1/3", a_valid, a_dest); end
        n_cmp++; if (a_val1 !== 32'h11 || a_cmd !== 4'h2 || a_wb !== 1'b1) begin n_bad++; $display("FAIL adv_data got %0h/%0h/%0h want 11/2/1", a_val1, a_cmd, a_wb); end
    endtask

    task automatic test_load_use_1();
        do_reset();
        load_r5();
        set_instr(1'b1, 5'd6, 5'd5, 5'd2, 1'b0, 32'h22, 4'h1, 1'b0, 1'b1);
        #1;
        n_cmp++; if (a_id_ready !== 1'b0) begin n_bad++; $display("FAIL lu1_stall_ready got %0h want 0", a_id_ready); end
        tick();
        n_cmp++; if (a_valid !== 1'b0 || a_bcnt !== 16'd1) begin n_bad++; $display("FAIL lu1_bubble got %0h/%0d want 0/1", a_valid, a_bcnt); end
        n_cmp++; if (a_id_ready !== 1'b1) begin n_bad++; $display("FAIL lu1_resume_ready got %0h want 1", a_id_ready); end
        tick();
        n_cmp++; if (a_valid !== 1'b1 || a_dest !== 5'd6 || a_val1 !== 32'h22) begin n_bad++; $display("FAIL lu1_enter got %0h/%0d/%0h want 1/6/22", a_valid, a_dest, a_val1); end
        // src2 matches but is not read: no stall.
        do_reset();
        load_r5();
        set_instr(1'b1, 5'd6, 5'd1, 5'd5, 1'b0, 32'h33, 4'h1, 1'b0, 1'b1);
        #1;
        n_cmp++; if (a_id_ready !== 1'b1) begin n_bad++; $display("FAIL lu1_src2_unused_ready got %0h want 1", a_id_ready); end
        tick();
        n_cmp++; if (a_valid !== 1'b1 || a_bcnt !== 16'd0) begin n_bad++; $display("FAIL lu1_src2_unused got %0h/%0d want 1/0", a_valid, a_bcnt); end
        do_reset();
        load_r5();
        set_instr(1'b1, 5'd6, 5'd1, 5'd5, 1'b1, 32'h33, 4'h1, 1'b0, 1'b1);
        #1;
        n_cmp++; if (a_id_ready !== 1'b0) begin n_bad++; $display("FAIL lu1_src2_used_ready got %0h want 0", a_id_ready); end
    endtask

    task automatic test_stall3_backpressure();
        int low = 0;
        do_reset();
        load_r5();
        set_instr(1'b1, 5'd6, 5'd5, 5'd2, 1'b0, 32'h44, 4'h3, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            exe_ready = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            #1;
            if (b_id_ready) break;
            low++;
            tick();
        end
        n_cmp++; if (low !== 5) begin n_bad++; $display("FAIL st3_ready_low got %0d want 5", low); end
        n_cmp++; if (b_bcnt !== 16'd3 || b_valid !== 1'b0) begin n_bad++; $display("FAIL st3_bubbles got %0d/%0h want 3/0", b_bcnt, b_valid); end
        tick();
        n_cmp++; if (b_valid !== 1'b1 || b_dest !== 5'd6 || b_val1 !== 32'h44) begin n_bad++; $display("FAIL st3_enter got %0h/%0d/%0h want 1/6/44", b_valid, b_dest, b_val1); end
    endtask

    task automatic test_flush();
        do_reset();
        load_r5();
        set_instr(1'b1, 5'd6, 5'd5, 5'd2, 1'b0, 32'h55, 4'h3, 1'b0, 1'b1);
        tick();
        flush = 1'b1;
        #1;
        n_cmp++; if (b_id_ready !== 1'b0) begin n_bad++; $display("FAIL fl_stall_ready got %0h want 0", b_id_ready); end
        tick();
        flush = 1'b0;
        n_cmp++; if (b_valid !== 1'b0 || b_bcnt !== 16'd1) begin n_bad++; $display("FAIL fl_stall got %0h/%0d want 0/1", b_valid, b_bcnt); end
        #1;
        n_cmp++; if (b_id_ready !== 1'b1) begin n_bad++; $display("FAIL fl_stall_run got %0h want 1", b_id_ready); end
        tick();
        n_cmp++; if (b_valid !== 1'b1 || b_dest !== 5'd6) begin n_bad++; $display("FAIL fl_stall_enter got %0h/%0d want 1/6", b_valid, b_dest); end
        // Flush coincident with a hazard while EXE is back-pressured.
        do_reset();
        load_r5();
        set_instr(1'b1, 5'd7, 5'd5, 5'd2, 1'b0, 32'h66, 4'h3, 1'b0, 1'b1);
        flush = 1'b1; exe_ready = 1'b0;
        tick();
        flush = 1'b0; exe_ready = 1'b1;
        n_cmp++; if (b_valid !== 1'b0 || b_mr !== 1'b0 || b_bcnt !== 16'd0) begin n_bad++; $display("FAIL fl_haz got %0h/%0h/%0d want 0/0/0", b_valid, b_mr, b_bcnt); end
        #1;
        n_cmp++; if (b_id_ready !== 1'b1) begin n_bad++; $display("FAIL fl_haz_ready got %0h want 1", b_id_ready); end
        tick();
        n_cmp++; if (b_valid !== 1'b1 || b_dest !== 5'd7 || b_bcnt !== 16'd0) begin n_bad++; $display("FAIL fl_haz_enter got %0h/%0d/%0d want 1/7/0", b_valid, b_dest, b_bcnt); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        load_r5();
        set_instr(1'b1, 5'd6, 5'd5, 5'd2, 1'b0, 32'h77, 4'h3, 1'b0, 1'b1);
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (b_valid !== 1'b0 || b_bcnt !== 16'd0 || b_id_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid got %0h/%0d/%0h want 0/0/0", b_valid, b_bcnt, b_id_ready); end
        rst = 1'b1;
        #1;
        n_cmp++; if (b_id_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_run got %0h want 1", b_id_ready); end
    endtask

    task automatic test_reg0_and_saturate();
        do_reset();
        set_instr(1'b1, 5'd0, 5'd1, 5'd2, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1);
        tick();
        set_instr(1'b1, 5'd6, 5'd0, 5'd0, 1'b1, 32'h88, 4'h1, 1'b0, 1'b1);
        #1;
        n_cmp++; if (a_id_ready !== 1'b1) begin n_bad++; $display("FAIL r0_ready got %0h want 1", a_id_ready); end
        tick();
        n_cmp++; if (a_valid !== 1'b1 || a_bcnt !== 16'd0) begin n_bad++; $display("FAIL r0_enter got %0h/%0d want 1/0", a_valid, a_bcnt); end
        do_reset();
        force u1.r_bubble_cnt = 16'hFFFE;
        #1;
        release u1.r_bubble_cnt;
        load_r5();
        // A self-dependent load re-triggers the hazard every other cycle.
        set_instr(1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 32'h99, 4'h0, 1'b1, 1'b1);
        tick();
        n_cmp++; if (a_bcnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach got %0h want ffff", a_bcnt); end
        tick();
        n_cmp++; if (a_valid !== 1'b1 || a_dest !== 5'd5) begin n_bad++; $display("FAIL sat_enter got %0h/%0d want 1/5", a_valid, a_dest); end
        tick();
        n_cmp++; if (a_bcnt !== 16'hFFFF || a_valid !== 1'b0) begin n_bad++; $display("FAIL sat_hold got %0h/%0h want ffff/0", a_bcnt, a_valid); end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; exe_ready = 1'b1;
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        #2;
        test_reset();
        test_plain_advance();
        test_load_use_1();
        test_stall3_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_reg0_and_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_exe_hazard_pipe.md
Name: id_exe_hazard_pipe

Overview:
Parametrised ID→EXE pipeline register with built-in load-use hazard interlock, multi-cycle bubble insertion, branch flush and downstream back-pressure.
It takes already-decoded ID-stage operands and control bits and holds the EXE-stage copy. It stalls the front end and injects zeroed control (bubbles) when a load result is not yet available.
It replaces the single-cycle, purely combinational hazard zeroing with a registered, counted interlock.

Parameters:
DATA_W, 32, operand/value width
REG_ADDR_W, 5, register address width
CMD_W, 4, EXE command width
LOAD_STALL, 1, bubbles inserted per load-use hazard (legal 1..3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
id_valid  in  1  ID slot holds a real instruction
id_ready  out  1  ID may advance (IF/PC freeze when 0)
id_dest  in  REG_ADDR_W  destination register
id_src1  in  REG_ADDR_W  source 1 register
id_src2  in  REG_ADDR_W  source 2 register
id_uses_src2  in  1  src2 is actually read (R-type, store, BNE)
id_val1  in  DATA_W  operand 1
id_val2  in  DATA_W  operand 2 (register or extended immediate)
id_reg2  in  DATA_W  raw src2 value (store data)
id_exe_cmd  in  CMD_W  ALU command
id_mem_r_en, id_mem_w_en, id_wb_en, id_br_taken  in  1 each  control bits
exe_ready  in  1  EXE accepts a new entry this cycle
flush  in  1  taken branch resolved; kill ID→EXE contents
exe_valid  out  1  EXE entry valid
exe_dest, exe_src1, exe_src2  out  REG_ADDR_W  registered fields
exe_val1, exe_val2, exe_reg2  out  DATA_W  registered operands
exe_cmd  out  CMD_W  registered command
exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_br_taken  out  1 each  registered control
bubble_cnt  out  16  saturating count of inserted bubbles

Behaviour:
- Reset (rst=0, async): all exe_* outputs = 0, bubble_cnt = 0, state = RUN, stall counter = 0. id_ready = 0 while rst = 0.
- Hazard (combinational, evaluated only in RUN):
  - Fires when exe_valid & exe_mem_r_en & exe_wb_en & exe_dest != 0 & id_valid.
  - The ID instruction must also match: id_src1 == exe_dest, or (id_uses_src2 & id_src2 == exe_dest).
  - Register 0 never causes a hazard.
- Advance condition: adv = exe_ready.
  - When adv = 0, every exe_* register holds, the counter holds, and id_ready = 0.
- FSM RUN:
  - id_ready = exe_ready & !hazard.
  - On adv & !hazard: load all id_* fields into exe_*, with exe_valid = id_valid.
  - On adv & hazard: load a bubble (exe_valid and all control/cmd = 0; data fields don't-care, drive 0), counter = LOAD_STALL−1, bubble_cnt += 1.
  - After a hazard: go to STALL if LOAD_STALL > 1, else stay in RUN.
- FSM STALL:
  - id_ready = 0.
  - On adv: load a bubble, bubble_cnt += 1, counter −= 1.
  - Return to RUN when the counter reaches 0 after the decrement.
  - Hazard is not re-evaluated in STALL.
- The ID instruction is held upstream throughout a stall and is accepted in the first RUN cycle with no hazard.
  - Total latency penalty is exactly LOAD_STALL cycles when exe_ready = 1 throughout.
- Flush has top priority, regardless of exe_ready and state.
  - Next edge: exe_valid and all control = 0, state = RUN, counter = 0.
  - Flush does not increment bubble_cnt.
  - id_ready = 0 during the flush cycle.
- Simultaneous hazard and flush: flush wins, and no stall is entered.
- bubble_cnt saturates at 0xFFFF; it never wraps.
- Reset asserted mid-stall: immediate return to RUN with zeroed outputs.
- Latency: one cycle, ID inputs to exe_* outputs.

Test Plan:
- Reset: hold rst=0 with random inputs → all exe_* = 0, id_ready = 0, bubble_cnt = 0. Release rst → id_ready = 1.
- Plain advance: id_dest=3, id_val1=0x11, id_exe_cmd=4'h2, wb_en=1 → next cycle exe_dest=3, exe_val1=0x11, exe_cmd=2, exe_valid=1.
- Load-use, LOAD_STALL=1:
  - Stimulus: exe holds a load with dest=5; ID has src1=5.
  - Response: one bubble (exe_valid=0), id_ready=0 for 1 cycle, then the instruction enters; bubble_cnt=1.
  - Repeat with src2=5 and id_uses_src2=0 → no stall.
- LOAD_STALL=3 with exe_ready dropped for 2 cycles mid-stall → exactly 3 bubbles, counter frozen during back-pressure, id_ready low for 5 cycles.
- Flush during STALL, and flush coincident with a hazard → exe_valid=0 next edge, state RUN, bubble_cnt unchanged, next instruction accepted the following cycle.
- Load with dest=0 followed by a src1=0 user → no stall. Force bubble_cnt to 0xFFFF, then trigger a hazard → remains 0xFFFF.
